hh_spike_monitor: RTL

Downstream consumer of the Hodgkin-Huxley neuron core. It takes the neuron's `spike` flag and 8-bit membrane `state` and turns them into spike-train statistics: it counts spikes per fixed window, measures the inter-spike interval (ISI), and applies a refractory filter. Its registered outputs drive the bidirectional pins of the tapeout top.

---
 rtl/hh_pkg.sv | 21 ++
 rtl/hh_spike_refract.sv | 62 ++++++
 rtl/hh_spike_monitor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hh_pkg.sv
// Shared types and defaults for the Hodgkin-Huxley spike monitor.
package hh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFRACT = 2'd1,
    ST_RUN     = 2'd2
  } hh_mon_state_t;

  localparam int HH_WIN_W   = 16;
  localparam int HH_ISI_W   = 16;
  localparam int HH_REFRACT = 4;

  localparam logic [7:0] HH_RATE_MAX = 8'd255;

  // Saturating increment for the 8-bit spike count.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && (v != HH_RATE_MAX)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/hh_spike_refract.sv
// Spike edge detection plus IDLE/REFRACT/RUN refractory FSM; emits a one-cycle accept strobe.
module hh_spike_refract
  import hh_pkg::*;
#(
  parameter int REFRACT = HH_REFRACT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clr,
  input  logic       spike,
  output logic       accept,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_REFRACT = ST_REFRACT;
  localparam logic [1:0] S_RUN     = ST_RUN;
  localparam logic [7:0] R_LOAD    = 8'(REFRACT - 1);

  logic       spike_q;
  logic [1:0] st;
  logic [7:0] rcnt;

  // spike_q follows spike regardless of ena/clr so a held-high spike never
  // looks like a fresh edge once the block resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_q <= 1'b0;
    else        spike_q <= spike;
  end

  // accept is a single-cycle strobe with no back-pressure: the parent must
  // consume it in the cycle it is high.
  assign accept = spike & ~spike_q & ena & ~clr & (st != S_REFRACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_IDLE;
      rcnt <= 8'd0;
    end else if (clr) begin
      st   <= S_IDLE;
      rcnt <= 8'd0;
    end else if (ena) begin
      case (st)
        S_IDLE, S_RUN: begin
          if (accept) begin
            st   <= S_REFRACT;
            rcnt <= R_LOAD;
          end
        end
        S_REFRACT: begin
          if (rcnt == 8'd0) st   <= S_RUN;
          else              rcnt <= rcnt - 8'd1;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = st;

endmodule

// File: rtl/hh_spike_monitor.sv
// Spike-train statistics: windowed rate, inter-spike interval, refractory filter.
// Optional per-window peak of state enabled by HH_SPIKE_MON_PEAK_EN.
module hh_spike_monitor
  import hh_pkg::*;
#(
  parameter int WIN_W   = HH_WIN_W,
  parameter int ISI_W   = HH_ISI_W,
  parameter int REFRACT = HH_REFRACT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic             spike,
  input  logic [7:0]       state,
  output logic [7:0]       rate_out,
  output logic             win_valid,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             isi_ovf
`ifdef HH_SPIKE_MON_PEAK_EN
  ,
  output logic [7:0]       peak_out
`endif
);

  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [ISI_W-1:0] ISI_ONE = {{(ISI_W-1){1'b0}}, 1'b1};
  // Counter stops one short of all-ones so a reported all-ones ISI means overflow.
  localparam logic [ISI_W-1:0] ISI_MAX = {{(ISI_W-1){1'b1}}, 1'b0};
  localparam logic [ISI_W-1:0] ISI_PRE = {{(ISI_W-2){1'b1}}, 2'b01};

  logic             accept;
  logic [1:0]       fsm_state;
  logic             counting;
  logic             win_tc;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       spk_cnt;
  logic [7:0]       spk_next;
  logic [ISI_W-1:0] isi_cnt;

  hh_spike_refract #(.REFRACT(REFRACT)) u_refract (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clr       (clr),
    .spike     (spike),
    .accept    (accept),
    .state_dbg (fsm_state)
  );

  assign counting = (fsm_state != ST_IDLE);
  assign win_tc   = &win_cnt;
  assign spk_next = sat_inc8(spk_cnt, accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      spk_cnt   <= 8'd0;
      rate_out  <= 8'd0;
      win_valid <= 1'b0;
    end else if (clr) begin
      win_cnt   <= '0;
      spk_cnt   <= 8'd0;
      rate_out  <= 8'd0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (ena) begin
        win_cnt <= win_cnt + WIN_ONE;
        if (win_tc) begin
          rate_out  <= spk_next;
          win_valid <= 1'b1;
          spk_cnt   <= 8'd0;
        end else begin
          spk_cnt   <= spk_next;
        end
      end
    end
  end

  // An accept is only possible in IDLE or RUN; only the RUN case has a
  // previous edge to measure against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt   <= '0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
      isi_ovf   <= 1'b0;
    end else if (clr) begin
      isi_cnt   <= '0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
      isi_ovf   <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (ena) begin
        if (accept) begin
          if (counting) begin
            isi_out   <= isi_cnt + ISI_ONE;
            isi_valid <= 1'b1;
          end
          isi_cnt <= '0;
        end else if (counting) begin
          if (isi_cnt != ISI_MAX) isi_cnt <= isi_cnt + ISI_ONE;
          if (isi_cnt >= ISI_PRE) isi_ovf <= 1'b1;
        end
      end
    end
  end

`ifdef HH_SPIKE_MON_PEAK_EN
  logic [7:0] peak_q;
  logic [7:0] peak_next;

  assign peak_next = (state > peak_q) ? state : peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q   <= 8'd0;
      peak_out <= 8'd0;
    end else if (clr) begin
      peak_q   <= 8'd0;
      peak_out <= 8'd0;
    end else if (ena) begin
      if (win_tc) begin
        peak_out <= peak_next;
        peak_q   <= 8'd0;
      end else begin
        peak_q   <= peak_next;
      end
    end
  end
`else
  logic unused_state;
  assign unused_state = ^state;
`endif

endmodule
